// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// sram_arbiter: three-port arbiter for one asynchronous 512Kx8 SRAM.
//
// Ports
//   clk, rst_n                    clock; asynchronous active-low reset
//   vid_req/vid_addr              video read-only request and address
//   vid_ack/vid_dout              one-cycle completion pulse; read data (held)
//   cpu_req/cpu_we/addr/din       CPU request (write when cpu_we=1)
//   cpu_ack/cpu_dout              completion pulse; read data (held)
//   ldr_req/ldr_we/addr/din       boot-loader request
//   ldr_ack/ldr_dout              completion pulse; read data (held)
//   sram_addr/sram_data/sram_we_n SRAM address, bidirectional data, write strobe
//
// Fixed priority video > CPU > loader. A starvation counter lets the loader
// win after STARVE_LIMIT consecutive video/CPU grants. A read takes 2 cycles
// from grant to ack, a write takes 4 (setup, pulse, hold).
//
// Build option: define LOADER_PORT_EN to enable the loader port. When it is
// undefined the ldr_* inputs are ignored and ldr_ack/ldr_dout stay 0.
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_req,
  input  logic [18:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_dout,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [18:0] ldr_addr,
  input  logic [7:0]  ldr_din,
  output logic        ldr_ack,
  output logic [7:0]  ldr_dout,
  output logic [18:0] sram_addr,
  inout  wire  [7:0]  sram_data,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WSETUP = 3'd2,
    WPULSE = 3'd3,
    WHOLD  = 3'd4
  } state_t;

  localparam logic [1:0] PORT_VID = 2'd0;
  localparam logic [1:0] PORT_CPU = 2'd1;
  localparam logic [1:0] PORT_LDR = 2'd2;

  state_t      state_r;
  logic [1:0]  port_r;
  logic [7:0]  wdata_r;
  logic        data_oe_r;

  logic        ldr_ok_s;     // loader may take part in arbitration
  logic        ldr_first_s;  // loader has been starved and must win now
  logic        grant_s;
  logic [1:0]  sel_port_s;
  logic        sel_we_s;
  logic [18:0] sel_addr_s;
  logic [7:0]  sel_din_s;

  // The data bus is driven only while a write is in flight; reset clears
  // data_oe_r asynchronously so the bus is released immediately.
  assign sram_data = data_oe_r ? wdata_r : 8'hzz;

`ifdef LOADER_PORT_EN
  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];
  logic [3:0] starve_cnt_r;

  assign ldr_ok_s    = ldr_req;
  assign ldr_first_s = ldr_req && (starve_cnt_r == LIMIT);

  // Starvation counter: counts video/CPU grants taken while the loader waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= 4'd0;
    end else if (!ldr_req) begin
      starve_cnt_r <= 4'd0;
    end else if ((state_r == IDLE) && grant_s) begin
      if (sel_port_s == PORT_LDR) begin
        starve_cnt_r <= 4'd0;
      end else if (starve_cnt_r != LIMIT) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  logic unused_s;

  assign ldr_ok_s    = 1'b0;
  assign ldr_first_s = 1'b0;
  assign unused_s    = &{1'b0, ldr_req, STARVE_LIMIT[0]};
`endif

  // Arbitration: starved loader first, then video > CPU > loader.
  always_comb begin
    grant_s    = 1'b0;
    sel_port_s = PORT_VID;
    sel_we_s   = 1'b0;
    sel_addr_s = vid_addr;
    sel_din_s  = 8'h00;
    if (ldr_first_s) begin
      grant_s    = 1'b1;
      sel_port_s = PORT_LDR;
      sel_we_s   = ldr_we;
      sel_addr_s = ldr_addr;
      sel_din_s  = ldr_din;
    end else if (vid_req) begin
      grant_s    = 1'b1;
      sel_port_s = PORT_VID;
      sel_we_s   = 1'b0;
      sel_addr_s = vid_addr;
      sel_din_s  = 8'h00;
    end else if (cpu_req) begin
      grant_s    = 1'b1;
      sel_port_s = PORT_CPU;
      sel_we_s   = cpu_we;
      sel_addr_s = cpu_addr;
      sel_din_s  = cpu_din;
    end else if (ldr_ok_s) begin
      grant_s    = 1'b1;
      sel_port_s = PORT_LDR;
      sel_we_s   = ldr_we;
      sel_addr_s = ldr_addr;
      sel_din_s  = ldr_din;
    end else begin
      grant_s    = 1'b0;
    end
  end

  // Access FSM with registered SRAM controls, acks and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      port_r    <= PORT_VID;
      wdata_r   <= 8'h00;
      data_oe_r <= 1'b0;
      sram_addr <= 19'h00000;
      sram_we_n <= 1'b1;
      vid_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
      vid_dout  <= 8'h00;
      cpu_dout  <= 8'h00;
      ldr_dout  <= 8'h00;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      case (state_r)
        IDLE: begin
          // With no request the address register simply keeps its value.
          if (grant_s) begin
            port_r    <= sel_port_s;
            sram_addr <= sel_addr_s;
            wdata_r   <= sel_din_s;
            if (sel_we_s) begin
              state_r   <= WSETUP;
              data_oe_r <= 1'b1;
            end else begin
              state_r   <= READ;
            end
          end
        end
        READ: begin
          state_r <= IDLE;
          case (port_r)
            PORT_VID: begin vid_ack <= 1'b1; vid_dout <= sram_data; end
            PORT_CPU: begin cpu_ack <= 1'b1; cpu_dout <= sram_data; end
            PORT_LDR: begin ldr_ack <= 1'b1; ldr_dout <= sram_data; end
            default:  begin end
          endcase
        end
        WSETUP: begin
          state_r   <= WPULSE;
          sram_we_n <= 1'b0;
        end
        WPULSE: begin
          state_r   <= WHOLD;
          sram_we_n <= 1'b1;
        end
        WHOLD: begin
          // Address and data stay put through hold; bus released on exit.
          state_r   <= IDLE;
          data_oe_r <= 1'b0;
          case (port_r)
            PORT_CPU: cpu_ack <= 1'b1;
            PORT_LDR: ldr_ack <= 1'b1;
            default:  begin end
          endcase
        end
        default: begin
          state_r   <= IDLE;
          data_oe_r <= 1'b0;
          sram_we_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for sram_arbiter: stimulus pushes expected acks (port,
// data, cycle) into a queue; a negedge monitor pops and compares each ack.
module tb_sram_arbiter;
  localparam logic [1:0] P_VID = 2'd0;
  localparam logic [1:0] P_CPU = 2'd1;
  localparam logic [1:0] P_LDR = 2'd2;

  typedef struct packed {
    logic [1:0]  port;
    logic [7:0]  dout;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vid_req, cpu_req, cpu_we, ldr_req, ldr_we;
  logic [18:0] vid_addr, cpu_addr, ldr_addr;
  logic [7:0] cpu_din, ldr_din;
  logic vid_ack, cpu_ack, ldr_ack;
  logic [7:0] vid_dout, cpu_dout, ldr_dout;
  logic [18:0] sram_addr;
  wire  [7:0] sram_data;
  logic sram_we_n;

  logic [7:0] mem [0:524287];
  logic [31:0] cyc = 32'd0;
  int pass_cnt = 0;
  int chk_cnt = 0;
  int we_low_cnt = 0;
  int exp_we_low = 0;
  exp_t sb_q[$];

  sram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_din(ldr_din),
    .ldr_ack(ldr_ack), .ldr_dout(ldr_dout),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_we_n(sram_we_n)
  );

  // SRAM model. A two-state simulator cannot show Z on the bus, so the
  // model watches the arbiter's bus-drive enable to know when to respond.
  assign sram_data = dut.data_oe_r ? 8'hzz : mem[sram_addr];
  always @(negedge clk) if (!sram_we_n) mem[sram_addr] <= sram_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic [1:0] port, input logic [7:0] dout, input logic [31:0] c);
    exp_t e;
    e.port = port; e.dout = dout; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [1:0] port, input logic [7:0] dout);
    exp_t e;
    check("ack_expected", {31'd0, sb_q.size() != 0}, 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("ack_port", {30'd0, port}, {30'd0, e.port});
      check("ack_dout", {24'd0, dout}, {24'd0, e.dout});
      check("ack_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: compare every ack against the scoreboard; count strobe cycles.
  always @(negedge clk) begin
    if (!sram_we_n) we_low_cnt++;
    if (vid_ack || cpu_ack || ldr_ack)
      check("one_ack", 32'(vid_ack) + 32'(cpu_ack) + 32'(ldr_ack), 32'd1);
    if (vid_ack) sb_pop(P_VID, vid_dout);
    if (cpu_ack) sb_pop(P_CPU, cpu_dout);
    if (ldr_ack) sb_pop(P_LDR, ldr_dout);
  end

  task automatic set_req(input logic [1:0] port, input logic v, input logic we,
                         input logic [18:0] addr, input logic [7:0] din);
    case (port)
      P_VID: begin vid_req = v; vid_addr = addr; end
      P_CPU: begin cpu_req = v; cpu_we = we; cpu_addr = addr; cpu_din = din; end
      default: begin ldr_req = v; ldr_we = we; ldr_addr = addr; ldr_din = din; end
    endcase
  endtask

  // Raise a level request now; drop it in the cycle of the nacks-th ack.
  task automatic drive(input logic [1:0] port, input logic we, input logic [18:0] addr,
                       input logic [7:0] din, input int nacks);
    int got = 0;
    int budget = 0;
    logic a;
    set_req(port, 1'b1, we, addr, din);
    while (got < nacks && budget < 60) begin
      @(posedge clk); #1;
      budget++;
      a = (port == P_VID) ? vid_ack : (port == P_CPU) ? cpu_ack : ldr_ack;
      if (a) begin
        got++;
        if (got == nacks) set_req(port, 1'b0, we, addr, din);
      end
    end
    if (got < nacks) begin
      set_req(port, 1'b0, we, addr, din);
      check("ack_timeout", got, nacks);
    end
  endtask

  task automatic watch_read(input logic [18:0] addr);
    check("rd_bus_hiz_0", {31'd0, dut.data_oe_r}, 32'd0);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #2;
      check($sformatf("rd_bus_hiz_%0d", k), {31'd0, dut.data_oe_r}, 32'd0);
      if (k == 1) check("rd_addr", {13'd0, sram_addr}, {13'd0, addr});
    end
  endtask

  task automatic watch_write(input logic [18:0] addr, input logic [7:0] din);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #2;
      check($sformatf("wr_addr_%0d", k), {13'd0, sram_addr}, {13'd0, addr});
      check($sformatf("wr_data_%0d", k), {24'd0, sram_data}, {24'd0, din});
      check($sformatf("wr_we_n_%0d", k), {31'd0, sram_we_n}, (k == 2) ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] n;
    logic [18:0] a0;
    int viol;
    vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; ldr_req = 1'b0; ldr_we = 1'b0;
    vid_addr = 19'd0; cpu_addr = 19'd0; ldr_addr = 19'd0; cpu_din = 8'd0; ldr_din = 8'd0;
    mem[19'h2C000] = 8'hA5;
    mem[19'h00123] = 8'h5A;
    mem[19'h7FFFF] = 8'hFF;
    mem[19'h14000] = 8'h00;

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_bus_hiz", {31'd0, dut.data_oe_r}, 32'd0);
    check("rst_addr", {13'd0, sram_addr}, 32'd0);
    check("rst_acks", {29'd0, vid_ack, cpu_ack, ldr_ack}, 32'd0);
    check("rst_douts", {8'd0, vid_dout, cpu_dout, ldr_dout}, 32'd0);

    // CPU read pending at reset release: grant on first edge, ack 2 later
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h2C000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = cyc;
    push(P_CPU, 8'hA5, n + 32'd2);
    fork
      drive(P_CPU, 1'b0, 19'h2C000, 8'h00, 1);
      watch_read(19'h2C000);
    join

    // CPU write 3C; ack 4 cycles after grant, read data held from last read
    @(posedge clk); #1;
    n = cyc;
    push(P_CPU, 8'hA5, n + 32'd4);
    exp_we_low++;
    fork
      drive(P_CPU, 1'b1, 19'h14000, 8'h3C, 1);
      watch_write(19'h14000, 8'h3C);
    join

    // Readback and top-of-memory read
    @(posedge clk); #1;
    n = cyc;
    push(P_CPU, 8'h3C, n + 32'd2);
    drive(P_CPU, 1'b0, 19'h14000, 8'h00, 1);
    @(posedge clk); #1;
    n = cyc;
    push(P_CPU, 8'hFF, n + 32'd2);
    drive(P_CPU, 1'b0, 19'h7FFFF, 8'h00, 1);

    // Video and CPU together: video first, CPU 2 cycles after video ack
    @(posedge clk); #1;
    n = cyc;
    push(P_VID, 8'h5A, n + 32'd2);
    push(P_CPU, 8'hA5, n + 32'd4);
    fork
      drive(P_VID, 1'b0, 19'h00123, 8'h00, 1);
      drive(P_CPU, 1'b0, 19'h2C000, 8'h00, 1);
    join

    // Video request held through its ack is a new request
    @(posedge clk); #1;
    n = cyc;
    push(P_VID, 8'h5A, n + 32'd2);
    push(P_VID, 8'h5A, n + 32'd4);
    drive(P_VID, 1'b0, 19'h00123, 8'h00, 2);

`ifdef LOADER_PORT_EN
    // Starvation: 4 video grants, then the loader, then video again
    @(posedge clk); #1;
    n = cyc;
    for (int i = 1; i <= 4; i++) push(P_VID, 8'h5A, n + 32'(2 * i));
    push(P_LDR, 8'hFF, n + 32'd10);
    push(P_VID, 8'h5A, n + 32'd12);
    fork
      drive(P_VID, 1'b0, 19'h00123, 8'h00, 5);
      drive(P_LDR, 1'b0, 19'h7FFFF, 8'h00, 1);
    join
`else
    // Loader disabled: 100 cycles of ldr_req cause no SRAM activity
    @(posedge clk); #1;
    a0 = sram_addr;
    viol = 0;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 19'h00ABC; ldr_din = 8'h99;
    repeat (100) begin
      @(posedge clk); #1;
      if (sram_addr != a0 || !sram_we_n || ldr_ack || dut.data_oe_r) viol++;
    end
    ldr_req = 1'b0;
    check("ldr_disabled_quiet", viol, 32'd0);
    check("ldr_dout_zero", {24'd0, ldr_dout}, 32'd0);
`endif

    // Reset during the write pulse
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00055; cpu_din = 8'h77;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("pulse_we_n_low", {31'd0, sram_we_n}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("midrst_bus_hiz", {31'd0, dut.data_oe_r}, 32'd0);
    check("midrst_addr", {13'd0, sram_addr}, 32'd0);
    check("midrst_acks", {29'd0, vid_ack, cpu_ack, ldr_ack}, 32'd0);
    check("midrst_douts", {8'd0, vid_dout, cpu_dout, ldr_dout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Arbiter is idle again: fresh read acked 2 cycles after grant
    @(posedge clk); #1;
    n = cyc;
    push(P_CPU, 8'hA5, n + 32'd2);
    drive(P_CPU, 1'b0, 19'h2C000, 8'h00, 1);

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 32'd0);
    check("we_low_cycles", we_low_cnt, exp_we_low);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive grants to video/CPU while ldr_req is pending (range 1-15).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 vid_req  in  1  video fetch request; read-only port.
REQ-006 vid_addr  in  19  video SRAM address.
REQ-007 vid_ack  out  1  one-cycle pulse; vid_dout valid in same cycle.
REQ-008 vid_dout  out  8  video read data, held until next video ack.
REQ-009 cpu_req / cpu_we  in  1 / 1  CPU request; write when cpu_we=1.
REQ-010 cpu_addr / cpu_din  in  19 / 8  CPU address and write data.
REQ-011 cpu_ack / cpu_dout  out  1 / 8  completion pulse; read data, held.
REQ-012 ldr_req / ldr_we / ldr_addr / ldr_din  in  1/1/19/8  boot-loader port request.
REQ-013 ldr_ack / ldr_dout  out  1 / 8  completion pulse; read data, held.
REQ-014 sram_addr  out  19  SRAM address.
REQ-015 sram_data  inout  8  SRAM data bus; driven only in write states.
REQ-016 sram_we_n  out  1  SRAM write strobe, active low.

Function
REQ-017 FSM states: IDLE, READ, WSETUP, WPULSE, WHOLD.
REQ-018 IDLE arbitrates among asserted requests: video > CPU > loader; grant latches the winner's address, data and we into internal registers.
REQ-019 Starvation counter: increments on each video/CPU grant while ldr_req=1; saturates at STARVE_LIMIT; at STARVE_LIMIT the loader wins the next IDLE arbitration; counter clears on loader grant or when ldr_req=0.
REQ-020 Read: grant in IDLE cycle N -> READ in N+1 with sram_addr driven -> data registered at end of N+1 -> ack pulse and dout update in N+2 (state IDLE, may grant again in N+2).
REQ-021 Write: IDLE N -> WSETUP N+1 (addr, data driven, we_n=1) -> WPULSE N+2 (we_n=0) -> WHOLD N+3 (we_n=1, addr/data held) -> ack in N+4.
REQ-022 sram_addr and sram_data stable through all write states; sram_we_n never low outside WPULSE.
REQ-023 sram_data high-impedance in IDLE and READ.
REQ-024 Requests are level: requester holds req until its ack; req dropped after grant does not abort the access; req still high in the ack cycle is a new request.
REQ-025 At most one ack asserted per cycle; ack only to the granted port.
REQ-026 Video port ignores write; vid_we does not exist, video access is always READ.
REQ-027 No requests in IDLE: sram_addr holds last value, no acks.

Reset
REQ-028 While rst_n=0: state IDLE, sram_we_n=1, sram_data hi-Z, sram_addr=0, all acks 0, all dout 8'h00, starvation counter 0.
REQ-029 Reset asserted mid-write forces sram_we_n=1 and releases sram_data immediately (asynchronously); the interrupted access is never acknowledged.
REQ-030 First grant occurs in the first rising edge after rst_n deasserts with a request pending.

Configuration
REQ-031 Macro LOADER_PORT_EN: defined -> loader port arbitrated per REQ-018/019; undefined -> ldr_* inputs ignored, ldr_ack=0, ldr_dout=8'h00, starvation counter absent, STARVE_LIMIT unused.

Verification
REQ-032 Single CPU read addr 19'h2C000, SRAM model returns 8'hA5 -> cpu_ack exactly 2 cycles after grant, cpu_dout=8'hA5, sram_data hi-Z throughout.
REQ-033 CPU write 8'h3C to 19'h14000 -> sram_we_n low exactly one cycle (WPULSE), addr/data stable WSETUP-WHOLD, cpu_ack 4 cycles after grant; readback returns 8'h3C.
REQ-034 vid_req and cpu_req asserted same cycle -> video granted first, vid_ack before cpu_ack, cpu_ack 2 cycles after vid_ack (read).
REQ-035 STARVE_LIMIT=4, vid_req held continuously, ldr_req held -> exactly 4 video grants, then loader grant, counter back to 0.
REQ-036 rst_n pulsed low during WPULSE -> sram_we_n=1 same cycle, no cpu_ack, state IDLE, all outputs at reset values.
REQ-037 LOADER_PORT_EN undefined, ldr_req=1 for 100 cycles with no other requests -> no SRAM access, ldr_ack never asserted.
